// File: rtl/tick_ctrl_pkg.sv
// rtl/tick_ctrl_pkg.sv - shared state encodings and switch bit indices for tick_ctrl
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } db_state_t;

    localparam int SW_EN     = 0;
    localparam int SW_SPD_LO = 1;
    localparam int SW_SPD_HI = 2;

endpackage

// File: rtl/tick_ctrl_if.sv
// rtl/tick_ctrl_if.sv - switch/button inputs and strobe outputs of tick_ctrl
interface tick_ctrl_if #(
    parameter int NB_SW = 4
) ();
    logic [NB_SW-1:0] i_sw;
    logic             i_btn_reverse;
    logic             o_valid;
    logic             o_reverse;

    modport master (output i_sw, output i_btn_reverse, input o_valid, input o_reverse);
    modport slave  (input i_sw, input i_btn_reverse, output o_valid, output o_reverse);
endinterface

// File: rtl/tick_ctrl_btn_debounce.sv
// rtl/tick_ctrl_btn_debounce.sv - button synchronizer and debounce FSM, one-cycle pulse per accepted press
module tick_ctrl_btn_debounce
    import tick_ctrl_pkg::*;
#(
    parameter int          NB_DEBOUNCE    = 20,
    parameter int unsigned DEBOUNCE_LIMIT = 2**NB_DEBOUNCE - 1
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [NB_DEBOUNCE-1:0] LIMIT = NB_DEBOUNCE'(DEBOUNCE_LIMIT);

    logic                   r_btn_meta;
    logic                   r_btn_s;
    db_state_t              r_state;
    logic [NB_DEBOUNCE-1:0] r_dcount;
    logic [NB_DEBOUNCE-1:0] w_dcount_inc;

    assign w_dcount_inc = r_dcount + NB_DEBOUNCE'(1);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
            r_state    <= ST_IDLE;
            r_dcount   <= '0;
        end else begin
            r_btn_meta <= i_btn;
            r_btn_s    <= r_btn_meta;
            case (r_state)
                ST_IDLE: begin
                    if (r_btn_s) begin
                        r_state  <= ST_WAIT_PRESS;
                        r_dcount <= '0;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (!r_btn_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_dcount <= w_dcount_inc;
                        if (w_dcount_inc == LIMIT) r_state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!r_btn_s) begin
                        r_state  <= ST_WAIT_RELEASE;
                        r_dcount <= '0;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (r_btn_s) begin
                        r_state <= ST_PRESSED;
                    end else begin
                        r_dcount <= w_dcount_inc;
                        if (w_dcount_inc == LIMIT) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Pulse coincides with the WAIT_PRESS -> PRESSED transition so pending sets on that same edge.
    assign o_press = (r_state == ST_WAIT_PRESS) && r_btn_s && (w_dcount_inc == LIMIT);

endmodule

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - switch-selected prescaler strobe with debounced reverse request aligned to it
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int          NB_COUNTER     = 32,
    parameter int          NB_SW          = 4,
    parameter int unsigned LIMIT_0        = 2**(NB_COUNTER-10) - 1,
    parameter int unsigned LIMIT_1        = 2**(NB_COUNTER-11) - 1,
    parameter int unsigned LIMIT_2        = 2**(NB_COUNTER-12) - 1,
    parameter int unsigned LIMIT_3        = 2**(NB_COUNTER-13) - 1,
    parameter int          NB_DEBOUNCE    = 20,
    parameter int unsigned DEBOUNCE_LIMIT = 2**NB_DEBOUNCE - 1
) (
    input  logic        clock,
    input  logic        i_reset,
    tick_ctrl_if.slave  bus
);

    logic [NB_SW-1:0]      r_sw_meta;
    logic [NB_SW-1:0]      r_sw_s;
    logic [NB_COUNTER-1:0] r_counter;
    logic                  r_pending;
    logic                  r_valid;
    logic                  r_reverse;

    logic [NB_COUNTER-1:0] w_limit;
    logic                  w_en;
    logic                  w_fire;
    logic                  w_press;
    logic                  w_unused_sw;

    tick_ctrl_btn_debounce #(
        .NB_DEBOUNCE    (NB_DEBOUNCE),
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_btn_debounce (
        .clock   (clock),
        .i_reset (i_reset),
        .i_btn   (bus.i_btn_reverse),
        .o_press (w_press)
    );

    always_comb begin
        w_limit = NB_COUNTER'(LIMIT_0);
        case (r_sw_s[SW_SPD_HI:SW_SPD_LO])
            2'b00: w_limit = NB_COUNTER'(LIMIT_0);
            2'b01: w_limit = NB_COUNTER'(LIMIT_1);
            2'b10: w_limit = NB_COUNTER'(LIMIT_2);
            2'b11: w_limit = NB_COUNTER'(LIMIT_3);
            default: w_limit = NB_COUNTER'(LIMIT_0);
        endcase
    end

    // >= so a speed change that leaves the counter beyond the new limit fires at once instead of wrapping.
    assign w_en        = r_sw_s[SW_EN];
    assign w_fire      = w_en && (r_counter >= w_limit);
    assign w_unused_sw = ^{1'b0, r_sw_s[NB_SW-1:SW_SPD_HI+1]};

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sw_meta <= '0;
            r_sw_s    <= '0;
            r_counter <= '0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_reverse <= 1'b0;
        end else begin
            r_sw_meta <= bus.i_sw;
            r_sw_s    <= r_sw_meta;
            if (w_fire)
                r_counter <= '0;
            else if (w_en)
                r_counter <= r_counter + NB_COUNTER'(1);
            r_valid   <= w_fire;
            r_reverse <= w_fire && r_pending;
            // A press landing on the consuming strobe wins, so no request is lost.
            if (w_press)
                r_pending <= 1'b1;
            else if (w_fire)
                r_pending <= 1'b0;
        end
    end

    assign bus.o_valid   = r_valid;
    assign bus.o_reverse = r_reverse;

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - randomized and directed self-checking bench for tick_ctrl against a behavioural model
module tb_tick_ctrl;

    localparam int NB_COUNTER = 8;
    localparam int NB_SW      = 4;
    localparam int DL         = 4;

    logic clock = 1'b0;
    logic i_reset;
    always #5 clock = ~clock;

    tick_ctrl_if #(.NB_SW(NB_SW)) bus ();

    tick_ctrl #(
        .NB_COUNTER     (NB_COUNTER),
        .NB_SW          (NB_SW),
        .LIMIT_0        (31),
        .LIMIT_1        (15),
        .LIMIT_2        (7),
        .LIMIT_3        (3),
        .NB_DEBOUNCE    (3),
        .DEBOUNCE_LIMIT (DL)
    ) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int lims [4] = '{31, 15, 7, 3};

    // Model: inputs seen by the logic lag the pins by two edges; debounce is a run-length rule.
    logic [3:0] m_sw_h0, m_sw_h1;
    bit         m_btn_h0, m_btn_h1;
    int         m_cnt;
    bit         m_pend;
    bit         m_lvl;
    int         m_run;
    bit         exp_valid, exp_rev;

    int cyc, last_valid_cyc, period, n_valid, n_rev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sw_h0 = '0; m_sw_h1 = '0; m_btn_h0 = 0; m_btn_h1 = 0;
        m_cnt = 0; m_pend = 0; m_lvl = 0; m_run = 0;
        exp_valid = 0; exp_rev = 0;
    endtask

    task automatic model_step(input logic [3:0] sw_pin, input bit btn_pin);
        logic [3:0] sw_s;
        bit btn_s, press, fire;
        sw_s = m_sw_h1; btn_s = m_btn_h1;
        m_sw_h1 = m_sw_h0; m_sw_h0 = sw_pin;
        m_btn_h1 = m_btn_h0; m_btn_h0 = btn_pin;
        press = 0;
        if (btn_s != m_lvl) m_run++; else m_run = 0;
        if (m_run == DL + 1) begin
            m_lvl = btn_s;
            m_run = 0;
            press = btn_s;
        end
        fire = 0;
        if (sw_s[0]) begin
            if (m_cnt >= lims[sw_s[2:1]]) begin
                fire = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        exp_valid = fire;
        exp_rev   = fire && m_pend;
        if (press) m_pend = 1;
        else if (fire) m_pend = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(bus.i_sw, bus.i_btn_reverse);
        #1;
        cyc++;
        chk("o_valid", bus.o_valid, exp_valid);
        chk("o_reverse", bus.o_reverse, exp_rev);
        if (bus.o_valid) begin
            n_valid++;
            period = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (bus.o_reverse) n_rev++;
    endtask

    task automatic rst_pulse(input int n);
        i_reset = 1'b0;
        model_reset();
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
            chk("rst_valid", bus.o_valid, 0);
            chk("rst_reverse", bus.o_reverse, 0);
        end
        #3 i_reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int max, output int n);
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < max) begin
            tick();
            n++;
            seen = bus.o_valid;
        end
        chk(tag, seen, 1);
    endtask

    task automatic press(input int hi, input int lo);
        bus.i_btn_reverse = 1'b1;
        repeat (hi) tick();
        bus.i_btn_reverse = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        int n, hold, guard, btn_left;
        i_reset = 1'b1;
        bus.i_sw = '0;
        bus.i_btn_reverse = 1'b0;
        cyc = 0; last_valid_cyc = 0; period = 0;
        model_reset();
        #1;

        // Reset and idle with everything disabled
        rst_pulse(3);
        n_valid = 0; n_rev = 0;
        repeat (100) tick();
        chk("idle_no_valid", n_valid, 0);
        chk("idle_no_reverse", n_rev, 0);

        // Speed select
        bus.i_sw = 4'b0111;
        repeat (40) tick();
        chk("period_fast", period, 4);
        bus.i_sw = 4'b0001;
        repeat (100) tick();
        chk("period_slow", period, 32);
        guard = 0;
        while (m_cnt != 20 && guard < 64) begin tick(); guard++; end
        chk("reach_cnt20", m_cnt, 20);
        bus.i_sw = 4'b0111;
        wait_valid("fast_switch_fire", 6, n);
        chk("fast_switch_lat", n, 3);
        repeat (20) tick();
        chk("period_after_switch", period, 4);

        // Enable hold
        bus.i_sw = 4'b0001;
        guard = 0;
        while (m_cnt != 10 && guard < 64) begin tick(); guard++; end
        bus.i_sw = 4'b0000;
        n_valid = 0;
        repeat (50) tick();
        chk("hold_no_valid", n_valid, 0);
        hold = m_cnt;
        bus.i_sw = 4'b0001;
        wait_valid("reenable_fire", 60, n);
        chk("reenable_lat", n, 3 + 31 - hold);

        // Debounce: short glitches, then a clean press at the fastest speed
        bus.i_sw = 4'b0111;
        n_rev = 0;
        repeat (4) press(3, 3);
        repeat (10) tick();
        chk("glitch_ignored", n_rev, 0);
        n_rev = 0;
        press(20, 40);
        chk("clean_press_one", n_rev, 1);

        // Two accepted presses inside one slow period collapse to one request
        bus.i_sw = 4'b0001;
        repeat (4) tick();
        wait_valid("slow_sync", 40, n);
        n_rev = 0;
        press(6, 6);
        press(6, 6);
        chk("both_pending", m_pend, 1);
        repeat (80) tick();
        chk("no_accumulate", n_rev, 1);

        // Reset during WAIT_PRESS
        press(4, 0);
        rst_pulse(2);
        n_rev = 0;
        wait_valid("restart_fire", 40, n);
        chk("restart_from_zero", n, 34);
        repeat (40) tick();
        chk("rst_wp_no_rev", n_rev, 0);

        // Reset with a request pending
        press(8, 6);
        chk("pend_before_rst", m_pend, 1);
        rst_pulse(2);
        n_rev = 0;
        repeat (80) tick();
        chk("rst_pend_no_rev", n_rev, 0);

        // Randomized traffic against the model
        btn_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0)
                bus.i_sw = {$urandom_range(0, 7) > 0 ? 3'($urandom) : 3'($urandom), $urandom_range(0, 3) != 0};
            if (btn_left == 0) begin
                bus.i_btn_reverse = ~bus.i_btn_reverse;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            if ($urandom_range(0, 499) == 0)
                rst_pulse($urandom_range(1, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/tick_ctrl.md
Name: tick_ctrl

Overview:
Control stage directly upstream of the LED shift register. Generates the one-cycle shift-enable strobe (o_valid) from a programmable prescaler selected by switches. Debounces the reverse push-button and delivers one reverse request (o_reverse) aligned to a strobe. Its outputs connect straight to the shift register's i_valid / i_reverse inputs.

Parameters:
NB_COUNTER, 32, prescaler counter width
NB_SW, 4, switch bus width; bit0 = enable, bits[2:1] = speed select, bit3 unused
LIMIT_0, 2**(NB_COUNTER-10)-1, terminal count for speed 2'b00 (slowest)
LIMIT_1, 2**(NB_COUNTER-11)-1, terminal count for speed 2'b01
LIMIT_2, 2**(NB_COUNTER-12)-1, terminal count for speed 2'b10
LIMIT_3, 2**(NB_COUNTER-13)-1, terminal count for speed 2'b11 (fastest)
NB_DEBOUNCE, 20, debounce counter width
DEBOUNCE_LIMIT, 2**NB_DEBOUNCE-1, number of stable cycles required to accept a button level

Ports:
clock  input  1  system clock; all logic on rising edge
i_reset  input  1  asynchronous, active-low reset
i_sw  input  NB_SW  raw asynchronous switches
i_btn_reverse  input  1  raw asynchronous reverse button, active-high
o_valid  output  1  one-cycle shift strobe
o_reverse  output  1  reverse request; meaningful only while o_valid=1

Behaviour:
- Reset (i_reset=0, asynchronous): counter=0, synchronizer stages=0, debounce FSM=IDLE, debounce counter=0, pending=0, o_valid=0, o_reverse=0. Reset may assert mid-count or mid-debounce; all state is discarded.
- Synchronizers: 2-FF synchronizers on i_sw and i_btn_reverse. All logic below uses only the synchronized values (sw_s, btn_s).
- Limit select: limit = LIMIT_0..LIMIT_3 by sw_s[2:1], combinational, effective immediately.
- Prescaler:
  - sw_s[0]=0: counter holds; o_valid=0.
  - sw_s[0]=1 and counter >= limit: counter<=0; o_valid<=1 for exactly one cycle.
  - Otherwise counter<=counter+1.
  - Strobe period = limit+1 cycles.
  - Switching to a faster speed with counter already above the new limit fires on the next enabled cycle (>= compare); no wrap through 2**NB_COUNTER.
- Outputs o_valid and o_reverse are registered.
- Debounce FSM (4 states):
  - IDLE: btn_s=1 -> WAIT_PRESS, clear dcount.
  - WAIT_PRESS: btn_s=0 -> IDLE. Else dcount++. When dcount==DEBOUNCE_LIMIT -> PRESSED and set pending.
  - PRESSED: btn_s=0 -> WAIT_RELEASE, clear dcount.
  - WAIT_RELEASE: btn_s=1 -> PRESSED. Else dcount++. When dcount==DEBOUNCE_LIMIT -> IDLE.
  - Net effect: exactly one request per accepted press. Glitches shorter than DEBOUNCE_LIMIT+1 cycles are ignored in both directions.
- Pending/reverse alignment:
  - On the cycle o_valid is asserted, o_reverse<=pending and pending is cleared.
  - o_reverse=0 whenever o_valid=0.
  - Press accepted while pending=1: no accumulation; pending stays 1.
  - Press accepted in the same cycle a strobe consumes pending: the set wins (pending=1 afterwards). This guarantees no lost request.
  - While disabled (sw_s[0]=0), pending is held until the next strobe.
- Latency: press-to-pending = 2 (sync) + DEBOUNCE_LIMIT+1 cycles after the raw rising edge.

Decomposition:
- Shared package/include holds the FSM state encodings (IDLE=2'd0, WAIT_PRESS=2'd1, PRESSED=2'd2, WAIT_RELEASE=2'd3) and the switch bit-index constants (SW_EN=0, SW_SPD_LO=1, SW_SPD_HI=2).
- Natural sub-module: btn_debounce. It contains the synchronizer, FSM and dcount, and outputs a one-cycle press pulse. tick_ctrl instantiates it and owns the prescaler, pending flag and output registers.

Test Plan:
(All with NB_COUNTER=8, LIMIT_0..3=31,15,7,3, DEBOUNCE_LIMIT=4.)
1. Reset/idle: i_reset=0 for 3 cycles, then 1 with i_sw=4'b0000 for 100 cycles -> o_valid=0 and o_reverse=0 throughout; asynchronous reset release mid-cycle is tolerated.
2. Speed select: i_sw=4'b0111 -> o_valid pulses every 4 cycles, each 1 cycle wide. Switch to 4'b0001 -> period 32. Switching 4'b0001->4'b0111 when counter=20 -> strobe on the next enabled cycle, then period 4.
3. Enable hold: at counter=10, clear i_sw[0] for 50 cycles -> no strobes. Re-set i_sw[0] -> first strobe after limit-10+1 cycles.
4. Debounce: button pulses of 3 cycles -> no o_reverse. Clean 20-cycle press at speed 2'b11 -> exactly one strobe with o_reverse=1; following strobes have o_reverse=0.
5. No accumulation: two accepted presses at speed 2'b00 within one 32-cycle period -> exactly one o_reverse=1 strobe.
6. Reset mid-operation: assert i_reset during WAIT_PRESS and with pending=1 -> after release, no o_reverse occurs and the counter restarts from 0.
